// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the datapath issue logic and the multiply/divide unit.
// The master side issues requests; the slave side is the unit itself.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi_out, lo_out, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi_out, lo_out, div_by_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Bit-serial signed multiply/divide unit feeding the HI/LO registers.
// Works on magnitudes for WIDTH cycles, fixes signs in one cycle, then strobes the result out.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          Clock,
    input  logic          Clear,
    mul_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               op_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic               b_zero_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH-1:0]   orig_a_r;
    logic [2*WIDTH-1:0] acc_r;

    logic               busy_r;
    logic               done_r;
    logic               dz_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               accept_s;
    logic               step_s;
    logic               fix_s;
    logic               emit_s;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] next_acc_s;
    logic [2*WIDTH-1:0] fixed_s;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return {WIDTH{1'b0}} - v;
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg_w(v) : v;
    endfunction

    // State register
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = accept_s ? RUN : IDLE;
            RUN:     state_s = (cnt_r == {CNT_W{1'b0}}) ? FIX : RUN;
            FIX:     state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Control strobes; busy_r gates acceptance so a start during the done pulse is dropped
    always_comb begin
        accept_s = 1'b0;
        step_s   = 1'b0;
        fix_s    = 1'b0;
        emit_s   = 1'b0;
        case (state_r)
            IDLE:    accept_s = bus.start & ~busy_r;
            RUN:     step_s   = 1'b1;
            FIX:     fix_s    = 1'b1;
            DONE:    emit_s   = 1'b1;
            default: accept_s = 1'b0;
        endcase
    end

    // One shift-add or restoring-divide step on the magnitudes
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                  + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        rem_sh_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        diff_s    = rem_sh_s - {1'b0, opnd_r};
        if (!op_r) begin
            next_acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end else if (!diff_s[WIDTH]) begin
            next_acc_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            next_acc_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction; remainder follows the dividend so the quotient truncates toward zero
    always_comb begin
        if (!op_r) begin
            fixed_s = (sign_a_r ^ sign_b_r) ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
        end else if (b_zero_r) begin
            fixed_s = {orig_a_r, {WIDTH{1'b1}}};
        end else begin
            fixed_s[WIDTH-1:0]       = (sign_a_r ^ sign_b_r) ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
            fixed_s[2*WIDTH-1:WIDTH] = sign_a_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
        end
    end

    // Operand latch, iteration accumulator and cycle counter
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= 1'b0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            b_zero_r <= 1'b0;
            opnd_r   <= {WIDTH{1'b0}};
            orig_a_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
        end else if (accept_s) begin
            cnt_r    <= CNT_W'(WIDTH - 1);
            op_r     <= bus.op;
            sign_a_r <= bus.a[WIDTH-1];
            sign_b_r <= bus.b[WIDTH-1];
            b_zero_r <= (bus.b == {WIDTH{1'b0}});
            orig_a_r <= bus.a;
            opnd_r   <= bus.op ? abs_w(bus.b) : abs_w(bus.a);
            acc_r    <= {{WIDTH{1'b0}}, (bus.op ? abs_w(bus.a) : abs_w(bus.b))};
        end else if (step_s) begin
            cnt_r    <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            acc_r    <= next_acc_s;
        end else if (fix_s) begin
            acc_r    <= fixed_s;
        end else begin
            acc_r    <= acc_r;
        end
    end

    // Registered outputs; hi/lo only change on the write strobe
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
        end else begin
            busy_r <= (state_r != IDLE);
            done_r <= emit_s;
            if (emit_s) begin
                hi_r <= acc_r[2*WIDTH-1:WIDTH];
                lo_r <= acc_r[WIDTH-1:0];
                dz_r <= op_r & b_zero_r;
            end else if (accept_s) begin
                dz_r <= 1'b0;
            end else begin
                dz_r <= dz_r;
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.hi_out      = hi_r;
    assign bus.lo_out      = lo_r;
    assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: a result table plus hand sequences
// for in-flight start, start coincident with done, and mid-operation reset.
module tb_mul_div_unit;
    logic Clock;
    logic Clear;

    mul_div_unit_if #(.WIDTH(32)) bus_if ();

    mul_div_unit #(.WIDTH(32)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus_if)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    vec_t vecs[12];
    int   total;
    int   bad;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_dz;
    int          r_done_cyc;
    int          r_done_cnt;
    int          r_busy_bad;
    int          r_dz_at1;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issue one operation; cycle n = n cycles after the accepting edge.
    // poke_cycle > 0 raises start (operands 100,100) during that cycle; clear_cycle > 0 pulls Clear low.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input int poke_cycle, input int clear_cycle);
        logic exp_busy;
        r_done_cyc = 0;
        r_done_cnt = 0;
        r_busy_bad = 0;
        r_dz_at1   = 0;
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        bus_if.a     = ~a;
        bus_if.b     = a ^ b;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) r_dz_at1 = int'(bus_if.div_by_zero);
            exp_busy = (clear_cycle > 0) ? (n <= clear_cycle) : (n <= 34);
            if (bus_if.busy !== exp_busy) r_busy_bad++;
            if (bus_if.done === 1'b1) begin
                if (r_done_cnt == 0) r_done_cyc = n;
                r_done_cnt++;
                r_hi = bus_if.hi_out;
                r_lo = bus_if.lo_out;
                r_dz = bus_if.div_by_zero;
            end
            if (n == poke_cycle) begin
                bus_if.start = 1'b1;
                bus_if.op    = 1'b0;
                bus_if.a     = 32'd100;
                bus_if.b     = 32'd100;
            end else begin
                bus_if.start = 1'b0;
            end
            Clear = (n == clear_cycle) ? 1'b0 : 1'b1;
        end
        if (r_done_cnt == 0) begin
            r_hi = bus_if.hi_out;
            r_lo = bus_if.lo_out;
            r_dz = bus_if.div_by_zero;
        end
    endtask

    task automatic check_normal(input string tag, input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        check({tag, " hi"}, r_hi, hi);
        check({tag, " lo"}, r_lo, lo);
        check({tag, " dz"}, {31'd0, r_dz}, {31'd0, dz});
        check({tag, " done_cycle"}, r_done_cyc, 32'd34);
        check({tag, " done_count"}, r_done_cnt, 32'd1);
        check({tag, " busy_profile_errors"}, r_busy_bad, 32'd0);
        check({tag, " dz_cleared_on_start"}, r_dz_at1, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        vecs[2]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{1'b1, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[8]  = '{1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vecs[9]  = '{1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
        vecs[11] = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

        Clear        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.op    = 1'b0;
        bus_if.a     = 32'd0;
        bus_if.b     = 32'd0;
        tick();
        tick();
        check("reset busy", {31'd0, bus_if.busy}, 32'd0);
        check("reset done", {31'd0, bus_if.done}, 32'd0);
        check("reset hi", bus_if.hi_out, 32'd0);
        check("reset lo", bus_if.lo_out, 32'd0);
        check("reset dz", {31'd0, bus_if.div_by_zero}, 32'd0);
        Clear = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0);
            check_normal($sformatf("vec%0d", i), vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz);
        end

        // Flag and result hold after the strobe until the next start
        run_op(1'b1, 32'd5, 32'd0, 0, 0);
        tick();
        tick();
        check("dz hold flag", {31'd0, bus_if.div_by_zero}, 32'd1);
        check("dz hold hi", bus_if.hi_out, 32'd5);
        check("dz hold lo", bus_if.lo_out, 32'hFFFFFFFF);

        // Start while busy is dropped
        run_op(1'b0, 32'd3, 32'd4, 10, 0);
        check_normal("poke_busy", 32'd0, 32'd12, 1'b0);

        // Start coincident with done is dropped
        run_op(1'b0, 32'd3, 32'd4, 34, 0);
        check_normal("poke_done", 32'd0, 32'd12, 1'b0);

        // Reset mid-operation aborts without a done
        run_op(1'b0, 32'd3, 32'd4, 0, 20);
        check("clear done_count", r_done_cnt, 32'd0);
        check("clear busy_profile_errors", r_busy_bad, 32'd0);
        check("clear hi", r_hi, 32'd0);
        check("clear lo", r_lo, 32'd0);
        check("clear dz", {31'd0, r_dz}, 32'd0);

        run_op(1'b0, 32'd3, 32'd4, 0, 0);
        check_normal("after_clear", 32'd0, 32'd12, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
